// File: rtl/booth_seq_mult_if.sv
// Operand/product handshake bundle for the sequential radix-4 Booth multiplier.
// The master drives operands and out_ready. The slave returns the product and status.
interface booth_seq_mult_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_p;
    logic                   busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle folded into a
// carry-save accumulator, followed by a single carry-propagate add.
module booth_seq_mult #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_seq_mult_if.slave    bus
);
    localparam int P  = 2 * WIDTH;
    localparam int N  = SIGNED ? (WIDTH / 2) : (WIDTH / 2 + 1);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [P-1:0]     a_q;
    logic [WIDTH+2:0] b_q;
    logic [P-1:0]     sum_q;
    logic [P-1:0]     carry_q;
    logic [CW-1:0]    cnt_q;
    logic [P-1:0]     p_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [P-1:0]     a_ext;
    logic [WIDTH+2:0] b_ext;
    logic             a_sign;
    logic             b_sign;

    logic [P-1:0]     mag;
    logic             neg;
    logic [P-1:0]     pp_d;
    logic [P-1:0]     maj;
    logic [P-1:0]     sum_d;
    logic [P-1:0]     carry_d;

    // Multiplier carries two extension bits on top (so the extra unsigned digit sees
    // a 0 sign) and the implicit b[-1]=0 at the bottom.
    assign a_sign = SIGNED & bus.in_a[WIDTH-1];
    assign b_sign = SIGNED & bus.in_b[WIDTH-1];
    assign a_ext  = {{WIDTH{a_sign}}, bus.in_a};
    assign b_ext  = {b_sign, b_sign, bus.in_b, 1'b0};

    // a_q is pre-shifted by 2i and b_q pre-shifted right by 2i, so the current digit
    // always sits in b_q[2:0] and its partial product needs no variable shifter.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        mag = '0;
        neg = 1'b0;
        case (b_q[2:0])
            3'b001, 3'b010: mag = a_q;
            3'b011:         mag = a_q << 1;
            3'b100: begin
                mag = a_q << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = a_q;
                neg = 1'b1;
            end
            default:        mag = '0;
        endcase

        pp_d    = neg ? (~mag + P'(1)) : mag;
        sum_d   = sum_q ^ carry_q ^ pp_d;
        maj     = (sum_q & carry_q) | (sum_q & pp_d) | (carry_q & pp_d);
        carry_d = {maj[P-2:0], 1'b0};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= a_ext;
                        b_q        <= b_ext;
                        sum_q      <= '0;
                        carry_q    <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end
                end

                S_CALC: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    a_q     <= a_q << 2;
                    b_q     <= b_q >> 2;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_ADD;
                    end
                end

                S_ADD: begin
                    p_q         <= sum_q + carry_q;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_DONE;
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = p_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult: a signed and an unsigned instance run side by
// side against a 64-bit reference product.
module tb_booth_seq_mult;
    localparam int W      = 32;
    localparam int N_RAND = 1500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0 = signed instance, index 1 = unsigned instance.
    logic         iv   [2];
    logic [W-1:0] ia   [2];
    logic [W-1:0] ib   [2];
    logic         ordy [2];
    logic         ir   [2];
    logic         ov   [2];
    logic         bz   [2];
    logic [2*W-1:0] op [2];

    booth_seq_mult_if #(.WIDTH(W)) if_s ();
    booth_seq_mult_if #(.WIDTH(W)) if_u ();

    assign if_s.in_valid  = iv[0];
    assign if_s.in_a      = ia[0];
    assign if_s.in_b      = ib[0];
    assign if_s.out_ready = ordy[0];
    assign ir[0] = if_s.in_ready;
    assign ov[0] = if_s.out_valid;
    assign op[0] = if_s.out_p;
    assign bz[0] = if_s.busy;

    assign if_u.in_valid  = iv[1];
    assign if_u.in_a      = ia[1];
    assign if_u.in_b      = ib[1];
    assign if_u.out_ready = ordy[1];
    assign ir[1] = if_u.in_ready;
    assign ov[1] = if_u.out_valid;
    assign op[1] = if_u.out_p;
    assign bz[1] = if_u.busy;

    booth_seq_mult #(.WIDTH(W), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
    booth_seq_mult #(.WIDTH(W), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u));

    int n_tests = 0;
    int n_fail  = 0;
    int tx [2];
    int rx [2];
    int done_cnt = 0;
    logic [63:0] sb0 [$];
    logic [63:0] sb1 [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [63:0] ae;
        logic [63:0] be;
        ae = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        be = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    task automatic push(input int k, input logic [63:0] v);
        if (k == 0) sb0.push_back(v);
        else        sb1.push_back(v);
        tx[k]++;
    endtask

    // Products are compared in the half cycle before the handshake edge.
    always @(negedge clk) begin
        if (rst_n && ov[0] && ordy[0]) begin
            rx[0]++;
            if (sb0.size() == 0) check("s_extra_product", 64'(rx[0]), 64'(tx[0]));
            else                 check("s_product", op[0], sb0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov[1] && ordy[1]) begin
            rx[1]++;
            if (sb1.size() == 0) check("u_extra_product", 64'(rx[1]), 64'(tx[1]));
            else                 check("u_product", op[1], sb1.pop_front());
        end
    end

    // Returns at #1 after the accept edge.
    task automatic start(input int k, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        iv[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (ir[k]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) push(k, model(a, b, k == 0));
        else    check("accept_timeout", {63'b0, ok}, 64'd1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic measure(input int k, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (ov[k]) break;
            if (bz[k]) bcnt++;
            lat++;
        end
    endtask

    task automatic drain(input int k);
        int qs;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            qs = (k == 0) ? sb0.size() : sb1.size();
            if (qs == 0 && ir[k]) return;
        end
        qs = (k == 0) ? sb0.size() : sb1.size();
        check("drain_timeout", 64'(qs), 64'd0);
    endtask

    task automatic rand_run(input int k);
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        for (int i = 0; i < N_RAND; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 11);
            if (sel == 0) a = 32'h8000_0000;
            if (sel == 1) b = 32'h8000_0000;
            if (sel == 2) a = 32'hFFFF_FFFF;
            if (sel == 3) b = 32'h0;
            start(k, a, b);
        end
        done_cnt++;
    endtask

    task automatic rdy_noise();
        while (done_cnt < 2) begin
            @(posedge clk);
            #1;
            ordy[0] = ($urandom_range(0, 3) != 0);
            ordy[1] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bcnt;
        logic [63:0] e;

        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ia[k] = '0; ib[k] = '0; ordy[k] = 1'b1;
            tx[k] = 0; rx[k] = 0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_in_ready",  64'(ir[k]), 64'd1);
            check("rst_out_valid", 64'(ov[k]), 64'd0);
            check("rst_out_p",     op[k],      64'd0);
            check("rst_busy",      64'(bz[k]), 64'd0);
        end
        rst_n = 1'b1;

        // Signed: -1 * -1, latency and busy duration.
        start(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        measure(0, lat, bcnt);
        check("s_latency", 64'(lat), 64'd17);
        check("s_busy_cycles", 64'(bcnt), 64'd17);
        drain(0);

        start(0, 32'h7FFF_FFFF, 32'h8000_0000); drain(0);
        start(0, 32'h8000_0000, 32'h8000_0000); drain(0);
        start(0, 32'h1234_5678, 32'h0);         drain(0);
        start(0, 32'h0,         32'hDEAD_BEEF); drain(0);

        // Unsigned: all-ones squared, latency is one extra digit.
        start(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        measure(1, lat, bcnt);
        check("u_latency", 64'(lat), 64'd18);
        check("u_busy_cycles", 64'(bcnt), 64'd18);
        drain(1);
        start(1, 32'h1234_5678, 32'h0);         drain(1);
        start(1, 32'h8000_0000, 32'h8000_0000); drain(1);

        // Backpressure with an ignored operand offer while the product is held.
        ordy[0] = 1'b0;
        e = model(32'h0000_BEEF, 32'hFFFF_0003, 1'b1);
        start(0, 32'h0000_BEEF, 32'hFFFF_0003);
        measure(0, lat, bcnt);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(ov[0]), 64'd1);
            check("bp_out_p",     op[0],      e);
            check("bp_in_ready",  64'(ir[0]), 64'd0);
            @(posedge clk);
            #1;
            iv[0] = 1'b1;
            ia[0] = 32'd5;
            ib[0] = 32'd7;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_back", 64'(ir[0]), 64'd1);
        check("bp_out_valid_low", 64'(ov[0]), 64'd0);
        repeat (25) @(negedge clk);
        check("bp_no_ghost_product", 64'(rx[0]), 64'(tx[0]));

        // Reset during the 6th CALC cycle aborts without emitting a product.
        start(0, 32'h1111_1111, 32'h2222_2222);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  64'(ir[0]), 64'd1);
        check("abort_out_valid", 64'(ov[0]), 64'd0);
        check("abort_out_p",     op[0],      64'd0);
        check("abort_busy",      64'(bz[0]), 64'd0);
        sb0.delete();
        tx[0]--;
        @(negedge clk);
        rst_n = 1'b1;
        start(0, 32'd3, 32'hFFFF_FFFB);
        drain(0);

        // Random traffic on both instances with random consumer stalls.
        fork
            rand_run(0);
            rand_run(1);
            rdy_noise();
        join
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        drain(0);
        drain(1);
        check("s_count", 64'(rx[0]), 64'(tx[0]));
        check("u_count", 64'(rx[1]), 64'(tx[1]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
